// File: rtl/rvx_mem_pkg.sv
// Shared types and constants for the RV32 data-memory path.
// Holds the LSU state encoding and the RV32I load/store Funct3 values.
package rvx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the MEM-stage LSU: legality check,
// store lane/strobe generation and load byte/half extract with extension.
module lsu_align
  import rvx_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic        legal,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [31:0] shifted_s;

  // Funct3 / alignment legality; unsigned variants exist only for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = (offset[0] == 1'b0);
      F3_W:    legal = (offset == 2'b00);
      F3_BU:   legal = ~we;
      F3_HU:   legal = ~we & (offset[0] == 1'b0);
      default: legal = 1'b0;
    endcase
  end

  // Store data replicated across lanes; loads carry no strobes.
  always_comb begin
    lane_wdata = 32'h0000_0000;
    lane_wstrb = 4'b0000;
    if (we) begin
      case (funct3[1:0])
        2'b00: begin
          lane_wdata = {4{store_data[7:0]}};
          lane_wstrb = 4'b0001 << offset;
        end
        2'b01: begin
          lane_wdata = {2{store_data[15:0]}};
          lane_wstrb = 4'b0011 << offset;
        end
        default: begin
          lane_wdata = store_data;
          lane_wstrb = 4'b1111;
        end
      endcase
    end else begin
      lane_wdata = 32'h0000_0000;
      lane_wstrb = 4'b0000;
    end
  end

  assign shifted_s = load_word >> {load_offset, 3'b000};

  // Load extract and sign/zero extension of the selected byte or half.
  always_comb begin
    load_data = shifted_s;
    case (load_funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: request/response handshake to the data bus,
// pipeline stall generation and response timeout detection.
module mem_stage_lsu
  import rvx_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_r;
  logic [CW-1:0] cnt_r;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        legal_s;
  logic [31:0] lane_wdata_s;
  logic [3:0]  lane_wstrb_s;
  logic [31:0] load_data_s;

  lsu_align u_align (
    .we          (MemWriteM),
    .funct3      (Funct3M),
    .offset      (ALUResultM[1:0]),
    .store_data  (WriteDataM),
    .legal       (legal_s),
    .lane_wdata  (lane_wdata_s),
    .lane_wstrb  (lane_wstrb_s),
    .load_funct3 (f3_r),
    .load_offset (off_r),
    .load_word   (bus_rdata),
    .load_data   (load_data_s)
  );

  // LSU sequencer: capture, handshake, response wait with timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      off_r   <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'b0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (MemReqM && legal_s) begin
            we_r    <= MemWriteM;
            f3_r    <= Funct3M;
            off_r   <= ALUResultM[1:0];
            addr_r  <= {ALUResultM[31:2], 2'b00};
            wdata_r <= lane_wdata_s;
            wstrb_r <= lane_wstrb_s;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            cnt_r   <= '0;
            state_r <= RESP;
          end
        end
        RESP: begin
          // A response in the timeout cycle still wins over the error.
          if (bus_rvalid) begin
            rdata_r <= we_r ? 32'h0000_0000 : load_data_s;
            err_r   <= 1'b0;
            state_r <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          rdata_r <= 32'h0000_0000;
          err_r   <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus_req   = (state_r == REQ);
  assign bus_we    = we_r;
  assign bus_addr  = addr_r;
  assign bus_wdata = wdata_r;
  assign bus_wstrb = wstrb_r;
  assign ReadDataM = rdata_r;
  assign BusErrM   = err_r;
  assign MisalignM = (state_r == IDLE) && MemReqM && !legal_s;
  assign StallM    = ((state_r == IDLE) && MemReqM && legal_s) ||
                     (state_r == REQ) || (state_r == RESP);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with a simple bus responder
// driven cycle by cycle from the access task.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, MisalignM, BusErrM;
  logic [31:0] ReadDataM;
  logic        bus_req, bus_we, bus_ready, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  // Results of the most recent access
  int          a_stalls, a_nreq, a_nchg;
  logic [31:0] a_rd, a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_err, a_we, a_done;

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int rdly, input logic [31:0] rdat,
                        input logic noresp);
    logic acc, take;
    int   wcnt;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = rdat;
    acc = 1'b0; wcnt = 0;
    a_stalls = 0; a_nreq = 0; a_nchg = 0; a_done = 1'b0; a_rd = 32'h0; a_err = 1'b0;
    a_addr = 32'h0; a_wdata = 32'h0; a_wstrb = 4'h0; a_we = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (bus_req) begin
        if (a_nreq == 0) begin
          a_addr = bus_addr; a_wdata = bus_wdata; a_wstrb = bus_wstrb; a_we = bus_we;
        end else if (bus_addr !== a_addr || bus_wdata !== a_wdata ||
                     bus_wstrb !== a_wstrb || bus_we !== a_we) begin
          a_nchg++;
        end
        a_nreq++;
      end
      if (!StallM) begin
        a_rd = ReadDataM; a_err = BusErrM; a_done = 1'b1;
        break;
      end
      a_stalls++;
      bus_rvalid = acc && !noresp;
      bus_ready  = bus_req && (wcnt >= rdly);
      if (bus_req && !bus_ready) wcnt++;
      take = bus_req && bus_ready;
      @(posedge clk);
      if (take) acc = 1'b1;
      @(negedge clk);
    end
    MemReqM = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({StallM, MisalignM, BusErrM, bus_req, bus_we, ReadDataM, bus_addr, bus_wdata, bus_wstrb} !== 105'h0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs stall=%b req=%b rd=%h addr=%h", StallM, bus_req, ReadDataM, bus_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_sw;
    access(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0);
    tests++; if (a_addr !== 32'h0000_1004) begin fails++; $display("FAIL sw_addr: got %h expected %h", a_addr, 32'h1004); end
    tests++; if (a_wstrb !== 4'b1111) begin fails++; $display("FAIL sw_wstrb: got %b expected 1111", a_wstrb); end
    tests++; if (a_wdata !== 32'hDEAD_BEEF || a_we !== 1'b1) begin fails++; $display("FAIL sw_wdata: got %h we=%b expected deadbeef we=1", a_wdata, a_we); end
    tests++; if (a_stalls !== 3) begin fails++; $display("FAIL sw_stalls: got %0d expected 3", a_stalls); end
    tests++; if (a_rd !== 32'h0 || a_err !== 1'b0) begin fails++; $display("FAIL sw_rdata: got %h err=%b expected 0 err=0", a_rd, a_err); end
  endtask

  task automatic test_load_extend;
    access(1'b0, 3'b000, 32'h0000_2003, 32'h0, 0, 32'h80FF_1234, 1'b0);
    tests++; if (a_rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_sext: got %h expected ffffff80", a_rd); end
    tests++; if (a_addr !== 32'h0000_2000 || a_wstrb !== 4'b0000 || a_we !== 1'b0) begin fails++; $display("FAIL lb_fields: addr=%h wstrb=%b we=%b expected 2000 0000 0", a_addr, a_wstrb, a_we); end
    access(1'b0, 3'b100, 32'h0000_2003, 32'h0, 0, 32'h80FF_1234, 1'b0);
    tests++; if (a_rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu_zext: got %h expected 00000080", a_rd); end
    access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 32'h80FF_1234, 1'b0);
    tests++; if (a_rd !== 32'hFFFF_80FF) begin fails++; $display("FAIL lh_sext: got %h expected ffff80ff", a_rd); end
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'h80FF_1234, 1'b0);
    tests++; if (a_rd !== 32'h0000_80FF) begin fails++; $display("FAIL lhu_zext: got %h expected 000080ff", a_rd); end
  endtask

  task automatic test_store_lanes;
    access(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 4, 32'h0, 1'b0);
    tests++; if (a_wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_wdata: got %h expected abcdabcd", a_wdata); end
    tests++; if (a_wstrb !== 4'b1100 || a_addr !== 32'h0000_3000) begin fails++; $display("FAIL sh_strb_addr: got %b %h expected 1100 00003000", a_wstrb, a_addr); end
    tests++; if (a_nchg !== 0 || a_nreq !== 5) begin fails++; $display("FAIL sh_stable: changes=%0d req_cycles=%0d expected 0 and 5", a_nchg, a_nreq); end
    tests++; if (a_stalls !== 7) begin fails++; $display("FAIL sh_stalls: got %0d expected 7", a_stalls); end
    access(1'b1, 3'b000, 32'h0000_1001, 32'h1234_5655, 0, 32'h0, 1'b0);
    tests++; if (a_wdata !== 32'h5555_5555 || a_wstrb !== 4'b0010) begin fails++; $display("FAIL sb_lanes: got %h %b expected 55555555 0010", a_wdata, a_wstrb); end
  endtask

  task automatic test_misalign;
    int reqs;
    reqs = 0;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h0000_4001;
    #1;
    tests++; if (MisalignM !== 1'b1 || StallM !== 1'b0) begin fails++; $display("FAIL lw_misalign: misalign=%b stall=%b expected 1 0", MisalignM, StallM); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (bus_req) reqs++;
    end
    tests++; if (reqs !== 0) begin fails++; $display("FAIL lw_misalign_noreq: got %0d req cycles expected 0", reqs); end
    MemWriteM = 1'b1; Funct3M = 3'b100; ALUResultM = 32'h0000_4000; #1;
    tests++; if (MisalignM !== 1'b1 || StallM !== 1'b0) begin fails++; $display("FAIL st_illegal_f3: misalign=%b stall=%b expected 1 0", MisalignM, StallM); end
    MemReqM = 1'b0; #1;
    tests++; if (MisalignM !== 1'b0) begin fails++; $display("FAIL misalign_noreq: got %b expected 0", MisalignM); end
  endtask

  task automatic test_timeout;
    access(1'b0, 3'b010, 32'h0000_5008, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
    tests++; if (a_done !== 1'b1 || a_err !== 1'b1 || a_rd !== 32'h0) begin fails++; $display("FAIL timeout_done: done=%b err=%b rd=%h expected 1 1 0", a_done, a_err, a_rd); end
    @(negedge clk);
    tests++; if (StallM !== 1'b0 || bus_req !== 1'b0 || BusErrM !== 1'b0) begin fails++; $display("FAIL timeout_idle: stall=%b req=%b err=%b expected 0 0 0", StallM, bus_req, BusErrM); end
    access(1'b0, 3'b010, 32'h0000_5008, 32'h0, 0, 32'h1234_5678, 1'b0);
    tests++; if (a_rd !== 32'h1234_5678 || a_err !== 1'b0 || a_stalls !== 3) begin fails++; $display("FAIL after_timeout_lw: rd=%h err=%b stalls=%0d expected 12345678 0 3", a_rd, a_err, a_stalls); end
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h0000_6000;
    @(negedge clk); bus_ready = 1'b1;
    @(negedge clk); bus_ready = 1'b0;
    #1;
    tests++; if (StallM !== 1'b1 || bus_req !== 1'b0) begin fails++; $display("FAIL resp_reached: stall=%b req=%b expected 1 0", StallM, bus_req); end
    #1; reset = 1'b1; MemReqM = 1'b0; #1;
    tests++; if (bus_req !== 1'b0 || StallM !== 1'b0 || bus_addr !== 32'h0) begin fails++; $display("FAIL async_reset: req=%b stall=%b addr=%h expected 0 0 0", bus_req, StallM, bus_addr); end
    @(negedge clk); reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); bus_rvalid = 1'b0;
    @(negedge clk); #1;
    tests++; if (ReadDataM !== 32'h0 || BusErrM !== 1'b0 || StallM !== 1'b0 || bus_req !== 1'b0) begin fails++; $display("FAIL stale_rvalid: rd=%h err=%b stall=%b req=%b expected 0 0 0 0", ReadDataM, BusErrM, StallM, bus_req); end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_load_extend;
    test_store_lanes;
    test_misalign;
    test_timeout;
    test_reset_in_resp;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
